// File: rtl/video_pkg.sv
// Video fetch shared definitions: raster geometry, window
// bounds, fetch slot numbering and cell address/colour helpers.
package video_pkg;

  localparam int H_TOTAL = 456;
  localparam int V_TOTAL = 311;
  localparam int ADDR_W  = 14;
  localparam int CNT_W   = 9;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DISP_W    = 9'd256;
  localparam cnt_t DISP_H    = 9'd192;
  localparam cnt_t PIX_DELAY = 9'd8;
  localparam cnt_t PIX_START = PIX_DELAY;
  localparam cnt_t PIX_END   = DISP_W + PIX_DELAY;

  localparam cnt_t HBLANK_START = 9'd320;
  localparam cnt_t HBLANK_END   = 9'd415;
  localparam cnt_t HSYNC_START  = 9'd344;
  localparam cnt_t HSYNC_END    = 9'd375;
  localparam cnt_t VBLANK_START = 9'd248;
  localparam cnt_t VBLANK_END   = 9'd255;
  localparam cnt_t VSYNC_START  = 9'd248;
  localparam cnt_t VSYNC_END    = 9'd251;
  localparam cnt_t IRQ_LINE     = VBLANK_START;
  localparam cnt_t IRQ_LEN      = 9'd64;

  localparam logic [2:0] SLOT_BMP_ADDR  = 3'd0;
  localparam logic [2:0] SLOT_BMP_CAP   = 3'd1;
  localparam logic [2:0] SLOT_ATTR_ADDR = 3'd2;
  localparam logic [2:0] SLOT_ATTR_CAP  = 3'd3;
  localparam logic [2:0] SLOT_LOAD      = 3'd7;

  // Spectrum screen layout interleaves the three row fields
  function automatic logic [12:0] bmp_offset(
    input logic [7:0] y,
    input logic [4:0] col
  );
    return {y[7:6], y[2:0], y[5:3], col};
  endfunction

  function automatic logic [12:0] attr_offset(
    input logic [7:0] y,
    input logic [4:0] col
  );
    return {3'b110, y[7:3], col};
  endfunction

  function automatic logic [3:0] cell_color(
    input logic [7:0] attr,
    input logic       pixel,
    input logic       flash
  );
    logic [2:0] ink;
    logic [2:0] paper;
    ink   = attr[2:0];
    paper = attr[5:3];
    if (attr[7] && flash) begin
      ink   = attr[5:3];
      paper = attr[2:0];
    end
    return {attr[6], pixel ? ink : paper};
  endfunction

endpackage

// File: rtl/video_sync.sv
// Raster timing: h/v counters, flash counter, registered
// sync/blank/irq aligned with the colour output register.
module video_sync
  import video_pkg::*;
#(
  parameter int HCOUNT = H_TOTAL,
  parameter int VCOUNT = V_TOTAL
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  output cnt_t hcount,
  output cnt_t vcount,
  output logic frame_start,
  output logic flash,
  output logic visible,
  output logic hsync,
  output logic vsync,
  output logic blank,
  output logic irq
);

  localparam cnt_t H_LAST = cnt_t'(HCOUNT - 1);
  localparam cnt_t V_LAST = cnt_t'(VCOUNT - 1);

  logic [4:0] flash_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic       hblank;
  logic       vblank;
  logic       hs_c;
  logic       vs_c;
  logic       irq_win;

  always_comb begin
    h_wrap      = hcount == H_LAST;
    v_wrap      = vcount == V_LAST;
    hblank      = hcount >= HBLANK_START && hcount <= HBLANK_END;
    vblank      = vcount >= VBLANK_START && vcount <= VBLANK_END;
    hs_c        = hcount >= HSYNC_START && hcount <= HSYNC_END;
    vs_c        = vcount >= VSYNC_START && vcount <= VSYNC_END;
    irq_win     = vcount == IRQ_LINE && hcount < IRQ_LEN;
    frame_start = hcount == '0 && vcount == '0;
    visible     = !(hblank || vblank);
    flash       = flash_cnt[4];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hcount    <= '0;
      vcount    <= '0;
      flash_cnt <= '0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      blank     <= 1'b1;
      irq       <= 1'b1;
    end else if (ce) begin
      hcount <= h_wrap ? '0 : hcount + 1'b1;
      if (h_wrap) begin
        vcount <= v_wrap ? '0 : vcount + 1'b1;
        if (v_wrap) flash_cnt <= flash_cnt + 1'b1;
      end
      hsync <= hs_c;
      vsync <= vs_c;
      blank <= !visible;
      irq   <= !irq_win;
    end
  end

endmodule

// File: rtl/video_fetch.sv
// Display fetch stage: drives video RAM reads one cell ahead,
// latches bitmap/attribute bytes and shifts out colour indices.
module video_fetch
  import video_pkg::*;
#(
  parameter int HCOUNT = H_TOTAL,
  parameter int VCOUNT = V_TOTAL,
  parameter int AW     = ADDR_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          page,
  input  logic [2:0]    border,
  output logic [AW-1:0] a1,
  input  logic [7:0]    q1,
  output logic [3:0]    color,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          irq
);

  cnt_t       hcount;
  cnt_t       vcount;
  logic       frame_start;
  logic       flash;
  logic       visible;
  logic       page_q;
  logic       cur_page;
  logic [2:0] slot;
  logic       fetch;
  logic       disp;
  logic [7:0] bmp_lat;
  logic [7:0] attr_lat;
  logic [7:0] shift;
  logic [7:0] attr_q;
  logic [3:0] pix_color;

  video_sync #(
    .HCOUNT(HCOUNT),
    .VCOUNT(VCOUNT)
  ) u_sync (
    .clock      (clock),
    .reset      (reset),
    .ce         (ce),
    .hcount     (hcount),
    .vcount     (vcount),
    .frame_start(frame_start),
    .flash      (flash),
    .visible    (visible),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank      (blank),
    .irq        (irq)
  );

  // The first fetch of a frame already uses the newly sampled page
  always_comb begin
    slot      = hcount[2:0];
    fetch     = vcount < DISP_H && hcount < DISP_W;
    disp      = vcount < DISP_H && hcount >= PIX_START
                && hcount < PIX_END;
    cur_page  = frame_start ? page : page_q;
    pix_color = cell_color(attr_q, shift[7], flash);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      page_q   <= 1'b0;
      a1       <= '0;
      bmp_lat  <= '0;
      attr_lat <= '0;
    end else if (ce) begin
      if (frame_start) page_q <= page;
      if (fetch) begin
        unique case (1'b1)
          slot == SLOT_BMP_ADDR:
            a1 <= AW'({cur_page, bmp_offset(vcount[7:0], hcount[7:3])});
          slot == SLOT_BMP_CAP:
            bmp_lat <= q1;
          slot == SLOT_ATTR_ADDR:
            a1 <= AW'({cur_page, attr_offset(vcount[7:0], hcount[7:3])});
          slot == SLOT_ATTR_CAP:
            attr_lat <= q1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift  <= '0;
      attr_q <= '0;
      color  <= '0;
    end else if (ce) begin
      if (fetch && slot == SLOT_LOAD) begin
        shift  <= bmp_lat;
        attr_q <= attr_lat;
      end else begin
        shift <= {shift[6:0], 1'b0};
      end
      unique case (1'b1)
        !visible: color <= '0;
        disp:     color <= pix_color;
        default:  color <= {1'b0, border};
      endcase
    end
  end

endmodule
